// File: rtl/usb3_lfps_arb.sv
// LFPS request arbiter: collects LFPS send requests, grants one type at a time
// by fixed priority, and tracks completion or acknowledge timeout.
module usb3_lfps_arb #(
  parameter logic [23:0] T_ACK_TIMEOUT = 24'd2000000
) (
  input  logic       slow_clk,
  input  logic       reset_n,
  input  logic       req_poll,
  input  logic       req_ping,
  input  logic       req_u1,
  input  logic       req_u2lb,
  input  logic       req_u3,
  input  logic       inhibit,
  input  logic       flush,
  input  logic       lfps_send_ack,
  output logic       lfps_send_poll,
  output logic       lfps_send_ping,
  output logic       lfps_send_u1,
  output logic       lfps_send_u2lb,
  output logic       lfps_send_u3,
  output logic [4:0] done,
  output logic       err_timeout,
  output logic       busy,
  output logic [4:0] pending
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

  localparam logic [23:0] ACK_LIMIT = T_ACK_TIMEOUT - 24'd1;

  state_t      state;
  state_t      state_next;
  logic [4:0]  req;
  logic [4:0]  pend_q;
  logic [4:0]  sel;
  logic [4:0]  grant_type;
  logic [4:0]  grant;
  logic [4:0]  send;
  logic [23:0] ack_cnt;
  logic        start;
  logic        ack_hit;
  logic        timeout_hit;

  assign req = {req_u3, req_u2lb, req_u1, req_ping, req_poll};

  // Fixed priority u3 > u2lb > u1 > ping > poll, one-hot result
  always_comb begin
    sel = 5'b00000;
    if (pend_q[4])      sel = 5'b10000;
    else if (pend_q[3]) sel = 5'b01000;
    else if (pend_q[2]) sel = 5'b00100;
    else if (pend_q[1]) sel = 5'b00010;
    else if (pend_q[0]) sel = 5'b00001;
  end

  assign start       = (state == IDLE) && (|pend_q) && !inhibit;
  assign ack_hit     = (state == WAIT_ACK) && lfps_send_ack;
  assign timeout_hit = (state == WAIT_ACK) && !lfps_send_ack && (ack_cnt == ACK_LIMIT);

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_next = ISSUE;
        ISSUE:    state_next = WAIT_ACK;
        WAIT_ACK: if (ack_hit || timeout_hit) state_next = GAP;
        GAP:      state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // grant is only nonzero in WAIT_ACK; masking with ack drops the request on the ack cycle
  always_comb begin
    busy = (state == ISSUE) || (state == WAIT_ACK);
    send = grant & {5{~lfps_send_ack}};
  end

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 5'b0;
      grant_type  <= 5'b0;
      grant       <= 5'b0;
      ack_cnt     <= 24'd0;
      done        <= 5'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 5'b0;
      err_timeout <= 1'b0;
      if (flush) begin
        pend_q <= 5'b0;
        grant  <= 5'b0;
      end else begin
        pend_q <= (pend_q & ~(start ? sel : 5'b0)) | req;
        if (start) grant_type <= sel;
        if (state == ISSUE) begin
          grant   <= grant_type;
          ack_cnt <= 24'd0;
        end else if (state == WAIT_ACK) begin
          ack_cnt <= ack_cnt + 24'd1;
          if (ack_hit) begin
            done  <= grant_type;
            grant <= 5'b0;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            grant       <= 5'b0;
          end
        end
      end
    end
  end

  assign pending        = pend_q;
  assign lfps_send_poll = send[0];
  assign lfps_send_ping = send[1];
  assign lfps_send_u1   = send[2];
  assign lfps_send_u2lb = send[3];
  assign lfps_send_u3   = send[4];

endmodule
